// File: rtl/approx_err_pkg.sv
// Shared types, widths and arithmetic helpers for the approximate-multiplier
// error accumulator.
package approx_err_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   localparam int unsigned OP_W   = 8;
   localparam int unsigned PROD_W = 16;
   localparam int unsigned ERR_W  = 17;
   localparam int unsigned SAT_W  = 64;

   // Unsigned add that clamps at the all-ones value of a width-bit accumulator.
   function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] acc,
                                                input logic [ERR_W-1:0] inc,
                                                input int unsigned      width);
      logic [SAT_W:0]   sum;
      logic [SAT_W-1:0] lim;
      lim = {SAT_W{1'b1}} >> (SAT_W - width);
      sum = {1'b0, acc} + {{(SAT_W + 1 - ERR_W){1'b0}}, inc};
      if (sum > {1'b0, lim})
         return lim;
      else
         return sum[SAT_W-1:0];
   endfunction

endpackage

// File: rtl/approx_err_calc.sv
// Registered error stage: exact product, signed error, magnitude and
// nonzero flag for one sample per cycle.
module approx_err_calc
   import approx_err_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [OP_W-1:0]   x,
   input  logic [OP_W-1:0]   y,
   input  logic [PROD_W-1:0] prod,
   input  logic              valid,
   output logic [ERR_W-1:0]  err,
   output logic [ERR_W-1:0]  abs_err,
   output logic              nz,
   output logic              err_valid
);

   logic signed [PROD_W-1:0] xs, ys, exact;
   logic signed [ERR_W-1:0]  diff;
   logic        [ERR_W-1:0]  mag;

   // 8x8 signed products span -16256..16384, so 16 bits never overflow.
   always_comb begin
      xs    = PROD_W'($signed(x));
      ys    = PROD_W'($signed(y));
      exact = xs * ys;
      diff  = ERR_W'($signed(prod)) - ERR_W'(exact);
      mag   = diff[ERR_W-1] ? ERR_W'(-diff) : ERR_W'(diff);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err       <= '0;
         abs_err   <= '0;
         nz        <= 1'b0;
         err_valid <= 1'b0;
      end else begin
         err       <= diff;
         abs_err   <= mag;
         nz        <= (diff != '0);
         err_valid <= valid;
      end
   end

endmodule

// File: rtl/approx_err_accum.sv
// Error-statistics collector for the approximate Booth multiplier: runs for
// NUM_SAMPLES accepted samples, then holds the results with done raised.
module approx_err_accum
   import approx_err_pkg::*;
#(
   parameter int unsigned NUM_SAMPLES = 65536,
   parameter int unsigned CNT_W       = 17,
   parameter int unsigned ACC_W       = 34
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OP_W-1:0]   in_x,
   input  logic [OP_W-1:0]   in_y,
   input  logic [PROD_W-1:0] in_prod,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  sample_cnt,
   output logic [CNT_W-1:0]  err_cnt,
   output logic [ACC_W-1:0]  sum_abs_err,
   output logic [ACC_W-1:0]  sum_err,
   output logic [ERR_W-1:0]  max_abs_err
);

   localparam logic [CNT_W-1:0] TOTAL = CNT_W'(NUM_SAMPLES);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(NUM_SAMPLES - 1);

   state_t             state, state_nx;
   logic [CNT_W-1:0]   accepted;
   logic               accept;
   logic               clr;
   logic [ERR_W-1:0]   c_err, c_abs;
   logic               c_nz, c_valid;
   logic [SAT_W-1:0]   abs_sum;

   assign accept = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // DRAIN leaves once the error stage is empty; the accumulators take the
   // last sample on that same edge, so DRAIN always lasts two cycles.
   always_comb begin
      state_nx = state;
      in_ready = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      clr      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               clr      = 1'b1;
               state_nx = RUN;
            end
         end
         RUN: begin
            busy     = 1'b1;
            in_ready = (accepted < TOTAL);
            if (in_valid && in_ready && (accepted == LAST))
               state_nx = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            if (!c_valid)
               state_nx = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               clr      = 1'b1;
               state_nx = RUN;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         accepted <= '0;
      else if (clr)
         accepted <= '0;
      else if (accept)
         accepted <= accepted + 1'b1;
   end

   approx_err_calc u_calc (
      .clk       (clk),
      .rst_n     (rst_n),
      .x         (in_x),
      .y         (in_y),
      .prod      (in_prod),
      .valid     (accept),
      .err       (c_err),
      .abs_err   (c_abs),
      .nz        (c_nz),
      .err_valid (c_valid)
   );

   assign abs_sum = sat_add(SAT_W'(sum_abs_err), c_abs, ACC_W);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sample_cnt  <= '0;
         err_cnt     <= '0;
         sum_abs_err <= '0;
         sum_err     <= '0;
         max_abs_err <= '0;
      end else if (clr) begin
         sample_cnt  <= '0;
         err_cnt     <= '0;
         sum_abs_err <= '0;
         sum_err     <= '0;
         max_abs_err <= '0;
      end else if (c_valid) begin
         sample_cnt  <= sample_cnt + 1'b1;
         err_cnt     <= err_cnt + CNT_W'(c_nz);
         sum_abs_err <= abs_sum[ACC_W-1:0];
         sum_err     <= sum_err + ACC_W'($signed(c_err));
         if (c_abs > max_abs_err)
            max_abs_err <= c_abs;
      end
   end

endmodule

// File: tb/tb_approx_err_accum.sv
// Directed bench for approx_err_accum: several instances with different run
// lengths share the sample bus; only the one that was started accepts data.
module tb_approx_err_accum;

   localparam logic [63:0] M34 = 64'h3_FFFF_FFFF;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [7:0]  in_x, in_y;
   logic [15:0] in_prod;
   logic [4:0]  st;
   logic [2:0]  sel;

   logic        rdy[4], bsy[4], dn[4];
   logic [16:0] sc[4], ec[4], mx[4];
   logic [33:0] sa[4], se[4];
   logic        rdy_s, bsy_s, dn_s;
   logic [16:0] sc_s, ec_s, mx_s, sa_s, se_s;

   logic        cur_ready, cur_busy, cur_done;
   logic [63:0] cur_sc, cur_ec, cur_sa, cur_se, cur_mx;

   int ntests = 0;
   int nfail  = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   approx_err_accum #(.NUM_SAMPLES(1)) u_n1 (
      .clk(clk), .rst_n(rst_n), .start(st[0]), .in_valid(in_valid), .in_ready(rdy[0]),
      .in_x(in_x), .in_y(in_y), .in_prod(in_prod), .busy(bsy[0]), .done(dn[0]),
      .sample_cnt(sc[0]), .err_cnt(ec[0]), .sum_abs_err(sa[0]), .sum_err(se[0]),
      .max_abs_err(mx[0]));

   approx_err_accum #(.NUM_SAMPLES(4)) u_n4 (
      .clk(clk), .rst_n(rst_n), .start(st[1]), .in_valid(in_valid), .in_ready(rdy[1]),
      .in_x(in_x), .in_y(in_y), .in_prod(in_prod), .busy(bsy[1]), .done(dn[1]),
      .sample_cnt(sc[1]), .err_cnt(ec[1]), .sum_abs_err(sa[1]), .sum_err(se[1]),
      .max_abs_err(mx[1]));

   approx_err_accum #(.NUM_SAMPLES(2)) u_n2 (
      .clk(clk), .rst_n(rst_n), .start(st[2]), .in_valid(in_valid), .in_ready(rdy[2]),
      .in_x(in_x), .in_y(in_y), .in_prod(in_prod), .busy(bsy[2]), .done(dn[2]),
      .sample_cnt(sc[2]), .err_cnt(ec[2]), .sum_abs_err(sa[2]), .sum_err(se[2]),
      .max_abs_err(mx[2]));

   approx_err_accum #(.NUM_SAMPLES(65536)) u_big (
      .clk(clk), .rst_n(rst_n), .start(st[3]), .in_valid(in_valid), .in_ready(rdy[3]),
      .in_x(in_x), .in_y(in_y), .in_prod(in_prod), .busy(bsy[3]), .done(dn[3]),
      .sample_cnt(sc[3]), .err_cnt(ec[3]), .sum_abs_err(sa[3]), .sum_err(se[3]),
      .max_abs_err(mx[3]));

   approx_err_accum #(.NUM_SAMPLES(3), .ACC_W(17)) u_sat (
      .clk(clk), .rst_n(rst_n), .start(st[4]), .in_valid(in_valid), .in_ready(rdy_s),
      .in_x(in_x), .in_y(in_y), .in_prod(in_prod), .busy(bsy_s), .done(dn_s),
      .sample_cnt(sc_s), .err_cnt(ec_s), .sum_abs_err(sa_s), .sum_err(se_s),
      .max_abs_err(mx_s));

   always_comb begin
      if (sel == 3'd4) begin
         cur_ready = rdy_s;  cur_busy = bsy_s;  cur_done = dn_s;
         cur_sc = 64'(sc_s); cur_ec = 64'(ec_s); cur_sa = 64'(sa_s);
         cur_se = 64'(se_s); cur_mx = 64'(mx_s);
      end else begin
         cur_ready = rdy[sel[1:0]];  cur_busy = bsy[sel[1:0]];  cur_done = dn[sel[1:0]];
         cur_sc = 64'(sc[sel[1:0]]); cur_ec = 64'(ec[sel[1:0]]); cur_sa = 64'(sa[sel[1:0]]);
         cur_se = 64'(se[sel[1:0]]); cur_mx = 64'(mx[sel[1:0]]);
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called at posedge+1; returns at posedge+1 just after the acceptance edge.
   task automatic send(input int x, input int y, input int p);
      int unsigned k;
      k = 0;
      in_x = 8'(x); in_y = 8'(y); in_prod = 16'(p); in_valid = 1'b1;
      while (!cur_ready && k < 50) begin
         tick();
         k++;
      end
      if (!cur_ready) check("send_ready_timeout", 64'(cur_ready), 64'd1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int unsigned k;
      k = 0;
      while (!cur_done && k < 20) begin
         tick();
         k++;
      end
      check(tag, 64'(cur_done), 64'd1);
   endtask

   task automatic pulse_start(input int idx);
      st[idx] = 1'b1;
      tick();
      st[idx] = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_ready"}, 64'(cur_ready), 64'd0);
      check({tag, "_busy"},  64'(cur_busy),  64'd0);
      check({tag, "_done"},  64'(cur_done),  64'd0);
      check({tag, "_scnt"},  cur_sc, 64'd0);
      check({tag, "_ecnt"},  cur_ec, 64'd0);
      check({tag, "_sabs"},  cur_sa, 64'd0);
      check({tag, "_serr"},  cur_se, 64'd0);
      check({tag, "_max"},   cur_mx, 64'd0);
   endtask

   initial begin
      int     acc, k, x, y, e, a, d;
      longint g_cnt, g_err, g_abs, g_sum, g_max;

      rst_n = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; in_prod = '0;
      st = '0; sel = 3'd0;
      tick(); tick();
      check_zero("reset_n1");
      rst_n = 1'b1;
      tick();
      check_zero("idle_n1");

      // NUM_SAMPLES=1; start coincident with valid must not accept the sample
      in_x = 8'd3; in_y = 8'd10; in_prod = 16'd20; in_valid = 1'b1; st[0] = 1'b1;
      check("n1_ready_at_start", 64'(cur_ready), 64'd0);
      tick();
      st[0] = 1'b0;
      check("n1_busy_run", 64'(cur_busy), 64'd1);
      send(3, 10, 20);
      check("n1_ready_drain", 64'(cur_ready), 64'd0);
      check("n1_busy_drain", 64'(cur_busy), 64'd1);
      check("n1_scnt_lat1", cur_sc, 64'd0);
      tick();
      check("n1_scnt_lat2", cur_sc, 64'd1);
      check("n1_done_early", 64'(cur_done), 64'd0);
      tick();
      check("n1_done", 64'(cur_done), 64'd1);
      check("n1_busy_done", 64'(cur_busy), 64'd0);
      repeat (3) tick();
      check("n1_done_hold", 64'(cur_done), 64'd1);
      check("n1_scnt", cur_sc, 64'd1);
      check("n1_ecnt", cur_ec, 64'd1);
      check("n1_sabs", cur_sa, 64'd10);
      check("n1_serr", cur_se, 64'h3_FFFF_FFF6);
      check("n1_max",  cur_mx, 64'd10);

      // restart from DONE clears statistics
      pulse_start(0);
      check("n1_re_done", 64'(cur_done), 64'd0);
      check("n1_re_busy", 64'(cur_busy), 64'd1);
      check("n1_re_scnt", cur_sc, 64'd0);
      check("n1_re_sabs", cur_sa, 64'd0);
      send(5, 7, 35);
      wait_done("n1_re_fin");
      check("n1_re_scnt2", cur_sc, 64'd1);
      check("n1_re_ecnt2", cur_ec, 64'd0);
      check("n1_re_max2",  cur_mx, 64'd0);

      // NUM_SAMPLES=4; start during DRAIN ignored
      sel = 3'd1;
      pulse_start(1);
      send(3, 10, 20);
      send(5, 7, 35);
      send(-128, -128, 16384);
      send(3, -10, -20);
      check("n4_ready_drain", 64'(cur_ready), 64'd0);
      check("n4_busy_drain", 64'(cur_busy), 64'd1);
      st[1] = 1'b1;
      tick();
      st[1] = 1'b0;
      check("n4_done_1cyc", 64'(cur_done), 64'd0);
      tick();
      check("n4_done_2cyc", 64'(cur_done), 64'd1);
      check("n4_scnt", cur_sc, 64'd4);
      check("n4_ecnt", cur_ec, 64'd2);
      check("n4_sabs", cur_sa, 64'd20);
      check("n4_serr", cur_se, 64'd0);
      check("n4_max",  cur_mx, 64'd10);

      // NUM_SAMPLES=2 with random valid, then valid held high
      sel = 3'd2;
      pulse_start(2);
      in_x = 8'd2; in_y = 8'd2; in_prod = 16'd5;
      acc = 0; k = 0;
      while (acc < 2 && k < 200) begin
         in_valid = 1'($urandom_range(0, 1));
         if (in_valid && cur_ready) acc++;
         tick();
         k++;
      end
      check("bp_accepts", 64'(acc), 64'd2);
      in_valid = 1'b1;
      check("bp_ready_low", 64'(cur_ready), 64'd0);
      repeat (4) tick();
      check("bp_ready_low2", 64'(cur_ready), 64'd0);
      in_valid = 1'b0;
      check("bp_done", 64'(cur_done), 64'd1);
      check("bp_scnt", cur_sc, 64'd2);
      check("bp_ecnt", cur_ec, 64'd2);
      check("bp_sabs", cur_sa, 64'd2);
      check("bp_serr", cur_se, 64'd2);
      check("bp_max",  cur_mx, 64'd1);

      // ACC_W=17: |err| 49152 x3 saturates, signed sum wraps to 114688
      sel = 3'd4;
      pulse_start(4);
      send(-128, -128, -32768);
      send(-128, -128, -32768);
      send(-128, -128, -32768);
      wait_done("sat_done");
      check("sat_scnt", cur_sc, 64'd3);
      check("sat_ecnt", cur_ec, 64'd3);
      check("sat_sabs", cur_sa, 64'd131071);
      check("sat_serr", cur_se, 64'd114688);
      check("sat_max",  cur_mx, 64'd49152);

      // reset in the middle of a run
      sel = 3'd3;
      pulse_start(3);
      for (int i = 0; i < 100; i++) send(i, 1, i + 1);
      tick();
      check("mid_scnt", cur_sc, 64'd100);
      check("mid_serr", cur_se, 64'd100);
      check("mid_busy", 64'(cur_busy), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check_zero("mid_reset");
      tick();
      rst_n = 1'b1;
      tick();

      // exhaustive sweep against a rounding-to-16 approximate multiplier model
      pulse_start(3);
      check_zero_stats: begin
         check("sw_scnt0", cur_sc, 64'd0);
         check("sw_busy0", 64'(cur_busy), 64'd1);
      end
      g_cnt = 0; g_err = 0; g_abs = 0; g_sum = 0; g_max = 0;
      for (int i = 0; i < 65536; i++) begin
         x = int'($signed(8'(i >> 8)));
         y = int'($signed(8'(i)));
         e = x * y;
         a = (e + 8) & ~15;
         d = a - e;
         g_cnt++;
         if (d != 0) g_err++;
         g_abs += (d < 0) ? -d : d;
         g_sum += d;
         if (longint'((d < 0) ? -d : d) > g_max) g_max = (d < 0) ? -d : d;
         if (i == 30000) st[3] = 1'b1;
         send(x, y, a);
         st[3] = 1'b0;
      end
      wait_done("sw_done");
      check("sw_scnt", cur_sc, 64'(g_cnt));
      check("sw_ecnt", cur_ec, 64'(g_err));
      check("sw_sabs", cur_sa, 64'(g_abs));
      check("sw_serr", cur_se, 64'(g_sum) & M34);
      check("sw_max",  cur_mx, 64'(g_max));

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule

// File: doc/approx_err_accum.md
Name: approx_err_accum

Overview:
- Downstream consumer of the 8x8 signed approximate Booth multiplier.
- Takes each operand pair (x, y) together with the approximate product the multiplier produced for it, and computes the exact product internally.
- Accumulates error statistics over a programmed run of NUM_SAMPLES accepted samples: error rate, mean error distance numerator, bias and worst case.
- Results are held stable for the test-bench harness after the run completes.

Parameters:
- NUM_SAMPLES, 65536, samples accepted per run (65536 = exhaustive 8x8 sweep); legal range 1..2^CNT_W-1.
- CNT_W, 17, width of the sample and error counters.
- ACC_W, 34, width of the sum_abs_err and sum_err accumulators.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins a new run and clears all statistics.
- in_valid  in  1  sample valid.
- in_ready  out  1  block accepts a sample this cycle.
- in_x  in  8  signed multiplier operand.
- in_y  in  8  signed multiplicand operand.
- in_prod  in  16  signed approximate product under test.
- busy  out  1  run in progress (RUN or DRAIN).
- done  out  1  statistics final and stable.
- sample_cnt  out  CNT_W  samples accumulated.
- err_cnt  out  CNT_W  samples with nonzero error.
- sum_abs_err  out  ACC_W  sum of |err|, unsigned, saturating.
- sum_err  out  ACC_W  sum of signed err, two's complement.
- max_abs_err  out  17  largest |err| seen.

Behaviour:
- Reset: all outputs and state are 0, FSM in IDLE. Reset mid-run aborts the run and discards partial statistics.
- Sample acceptance: a sample is accepted when in_valid && in_ready. in_valid while in_ready=0 is ignored, with no effect. in_ready is combinational from state and the accepted count only, never from in_valid.
- err_calc stage (registered, 1 cycle):
  - exact = in_x*in_y, 16-bit signed; range -16256..16384 fits with no overflow.
  - err = sext17(in_prod) - sext17(exact), 17-bit signed.
  - abs_err = |err|, 17-bit unsigned.
  - nz = (err != 0).
- Accumulate stage (registered, 1 cycle):
  - sample_cnt += 1.
  - err_cnt += nz.
  - sum_abs_err += abs_err, saturating at all-ones.
  - sum_err += sext(err), wrapping.
  - max_abs_err = max(max_abs_err, abs_err).
- Latency: an accepted sample is reflected in the statistic outputs 2 cycles after acceptance. The pipeline is fully pipelined at 1 sample/cycle.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: in_ready=0, busy=0, done=0. start -> clear all statistics and the accepted counter -> RUN.
  - RUN: busy=1. in_ready=1 while accepted < NUM_SAMPLES. The cycle the NUM_SAMPLES-th sample is accepted -> DRAIN.
  - DRAIN: in_ready=0, busy=1. Wait until both pipeline stages are empty -> DONE. Exactly 2 cycles.
  - DONE: done=1, busy=0, in_ready=0, outputs frozen. start -> clear, RUN (done drops the following cycle).
- start asserted in RUN or DRAIN is ignored.
- start coincident with in_valid in IDLE/DONE: the sample is not accepted, because in_ready=0 that cycle.
- NUM_SAMPLES=1: RUN lasts until the first acceptance, then DRAIN, then DONE.
- Statistic outputs update live during RUN/DRAIN; only the values with done=1 are architecturally final.

Decomposition:
- Package approx_err_pkg holds:
  - state enum {IDLE, RUN, DRAIN, DONE};
  - localparams OP_W=8, PROD_W=16, ERR_W=17;
  - saturating-add function for sum_abs_err.
- Sub-module approx_err_calc: the registered err_calc stage, with inputs x, y, prod and valid; outputs err, abs_err, nz and valid. The top level holds the FSM, the acceptance counter and the accumulators.

Test Plan:
- Reset then NUM_SAMPLES=1. Sequence: start, then in_x=3, in_y=10, in_prod=20. Required: exact 30, err=-10. At done: sample_cnt=1, err_cnt=1, sum_abs_err=10, sum_err=-10, max_abs_err=10.
- NUM_SAMPLES=4, with samples (3,10,20), (5,7,35), (-128,-128,16384), (3,-10,-20). Required: err_cnt=2, sum_abs_err=20, sum_err=0, max_abs_err=10, done 2 cycles after the 4th acceptance.
- Back-pressure check, NUM_SAMPLES=2. Toggle in_valid randomly, and hold in_valid=1 after the 2nd acceptance. Required: in_ready=0 from the cycle after the 2nd acceptance, sample_cnt=2, extra samples ignored.
- Wrap/saturation check: ACC_W=17, 3 samples of in_prod=-32768 with exact 16384 (abs 49152). Required: sum_abs_err saturates at 131071, and sum_err wraps to 17-bit two's complement.
- Reset mid-run: deassert rst_n in RUN after 100 samples. Required: all outputs 0 and state IDLE immediately. A following start gives a clean run.
- Exhaustive sweep, NUM_SAMPLES=65536: drive all x,y pairs through the real multiplier. Statistics must match the bench's golden model computed from the multiplier's reference behaviour, and start must be ignored during RUN.
